// File: rtl/uart_rx_pkg.sv
// Shared types and defaults for the UART receive-side FIFO controller.
package uart_rx_pkg;

  localparam int unsigned RX_FIFO_DEPTH_DEF = 16;
  localparam int unsigned RX_TIMEOUT_DEF    = 640;
  // Widest received word a FIFO entry can carry; narrower words are zero-extended.
  localparam int unsigned RX_DATA_W_MAX     = 32;

  typedef enum logic [1:0] {
    DISABLED = 2'd0,
    ARMED    = 2'd1,
    CAPTURE  = 2'd2,
    HOLD     = 2'd3
  } rx_ctrl_state_e;

  typedef struct packed {
    logic                     err;
    logic [RX_DATA_W_MAX-1:0] data;
  } rx_entry_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive FIFO storage: pointers, occupancy level and show-ahead head entry.
// Callers present only legal write/read strobes; flush overrides both.
module uart_rx_fifo
  import uart_rx_pkg::*;
#(
  parameter int unsigned DEPTH = RX_FIFO_DEPTH_DEF
) (
  input  logic                   PCLK,
  input  logic                   PRESETn,
  input  logic                   wr_en,
  input  rx_entry_t              wr_entry,
  input  logic                   rd_en,
  input  logic                   flush,
  output rx_entry_t              head_c,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full_c,
  output logic                   empty_c
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  rx_entry_t     mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // Pointer and level bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // Storage is intentionally not reset.
  always_ff @(posedge PCLK) begin
    if (wr_en && !flush) mem[wr_ptr] <= wr_entry;
  end

  assign full_c  = (level == LW'(DEPTH));
  assign empty_c = (level == '0);
  assign head_c  = empty_c ? '0 : mem[rd_ptr];

endmodule

// File: rtl/uart_rx_fifo_ctrl.sv
// UART receive controller: arms the receiver, captures frames into the FIFO,
// serves APB reads and raises data-threshold, timeout and overrun interrupts.
module uart_rx_fifo_ctrl
  import uart_rx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned DEPTH         = RX_FIFO_DEPTH_DEF,
  parameter int unsigned TIMEOUT_TICKS = RX_TIMEOUT_DEF
) (
  input  logic                   PCLK,
  input  logic                   PRESETn,
  input  logic                   rx_tick,
  input  logic                   rx_en,
  input  logic                   flush,
  input  logic [$clog2(DEPTH):0] rx_threshold,
  output logic                   RX_detect,
  input  logic                   rx_done,
  input  logic [DATA_WIDTH-1:0]  rx_data_out,
  input  logic                   prx_error,
  input  logic                   pop,
  output logic [DATA_WIDTH-1:0]  rd_data,
  output logic                   rd_err,
  output logic [$clog2(DEPTH):0] fifo_level,
  input  logic                   overrun_clr,
  output logic                   irq_rx_data,
  output logic                   irq_timeout,
  output logic                   irq_overrun
);

  localparam int unsigned TW = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_TICKS);

  rx_ctrl_state_e state_q, state_d;
  logic           rx_done_q;
  rx_entry_t      cap_q;
  logic [TW-1:0]  to_cnt_q, to_cnt_d;

  logic      rise_c;
  logic      capture_c;
  logic      push_req_c;
  logic      wr_en_c;
  logic      rd_en_c;
  logic      ovr_set_c;
  logic      full_c;
  logic      empty_c;
  rx_entry_t head_c;

  assign rise_c = rx_done & ~rx_done_q;

  // State register plus the registered outputs derived from it.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q   <= DISABLED;
      RX_detect <= 1'b0;
      rx_done_q <= 1'b0;
      cap_q     <= '0;
    end else begin
      state_q   <= state_d;
      RX_detect <= (state_d != DISABLED);
      rx_done_q <= rx_done;
      if (capture_c) begin
        cap_q.err  <= prx_error;
        cap_q.data <= RX_DATA_W_MAX'(rx_data_out);
      end
    end
  end

  // Next state; a capture already in CAPTURE completes even if rx_en drops.
  always_comb begin
    state_d    = state_q;
    capture_c  = 1'b0;
    push_req_c = 1'b0;
    case (state_q)
      DISABLED: if (rx_en) state_d = ARMED;
      ARMED: begin
        if (!rx_en) begin
          state_d = DISABLED;
        end else if (rise_c) begin
          capture_c = 1'b1;
          state_d   = CAPTURE;
        end
      end
      CAPTURE: begin
        push_req_c = 1'b1;
        state_d    = rx_en ? HOLD : DISABLED;
      end
      HOLD: begin
        if (!rx_en)        state_d = DISABLED;
        else if (!rx_done) state_d = ARMED;
      end
      default: state_d = DISABLED;
    endcase
  end

  // A full FIFO still accepts the word when the same cycle pops the head.
  assign rd_en_c   = pop & ~empty_c & ~flush;
  assign wr_en_c   = push_req_c & (~full_c | pop) & ~flush;
  assign ovr_set_c = push_req_c & full_c & ~pop;

  uart_rx_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .PCLK     (PCLK),
    .PRESETn  (PRESETn),
    .wr_en    (wr_en_c),
    .wr_entry (cap_q),
    .rd_en    (rd_en_c),
    .flush    (flush),
    .head_c   (head_c),
    .level    (fifo_level),
    .full_c   (full_c),
    .empty_c  (empty_c)
  );

  assign rd_data = DATA_WIDTH'(head_c.data);
  assign rd_err  = head_c.err;

  // Character timeout: counts idle ticks while data waits, saturating.
  always_comb begin
    to_cnt_d = to_cnt_q;
    if (flush || wr_en_c || rd_en_c || empty_c) begin
      to_cnt_d = '0;
    end else if (rx_tick && (to_cnt_q != TO_MAX)) begin
      to_cnt_d = to_cnt_q + TW'(1);
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      to_cnt_q    <= '0;
      irq_timeout <= 1'b0;
      irq_rx_data <= 1'b0;
      irq_overrun <= 1'b0;
    end else begin
      to_cnt_q    <= to_cnt_d;
      irq_timeout <= (to_cnt_d == TO_MAX);
      irq_rx_data <= (rx_threshold != '0) && (fifo_level >= rx_threshold);
      if (ovr_set_c)        irq_overrun <= 1'b1;
      else if (overrun_clr) irq_overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo_ctrl.sv
// Scoreboard bench for uart_rx_fifo_ctrl against a queue-based receive model.
module tb_uart_rx_fifo_ctrl;

  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned TO    = 640;
  localparam int unsigned LW    = $clog2(DEPTH) + 1;

  logic          PCLK = 1'b0;
  logic          PRESETn = 1'b0;
  logic          rx_tick = 1'b0;
  logic          rx_en = 1'b0;
  logic          flush = 1'b0;
  logic [LW-1:0] rx_threshold = '0;
  logic          RX_detect;
  logic          rx_done = 1'b0;
  logic [DW-1:0] rx_data_out = '0;
  logic          prx_error = 1'b0;
  logic          pop = 1'b0;
  logic [DW-1:0] rd_data;
  logic          rd_err;
  logic [LW-1:0] fifo_level;
  logic          overrun_clr = 1'b0;
  logic          irq_rx_data;
  logic          irq_timeout;
  logic          irq_overrun;

  int checks = 0;
  int failures = 0;

  logic [DW:0] model_q[$];
  logic [DW:0] sb_q[$];
  bit          model_ovr = 1'b0;

  uart_rx_fifo_ctrl #(
    .DATA_WIDTH    (DW),
    .DEPTH         (DEPTH),
    .TIMEOUT_TICKS (TO)
  ) dut (
    .PCLK         (PCLK),
    .PRESETn      (PRESETn),
    .rx_tick      (rx_tick),
    .rx_en        (rx_en),
    .flush        (flush),
    .rx_threshold (rx_threshold),
    .RX_detect    (RX_detect),
    .rx_done      (rx_done),
    .rx_data_out  (rx_data_out),
    .prx_error    (prx_error),
    .pop          (pop),
    .rd_data      (rd_data),
    .rd_err       (rd_err),
    .fifo_level   (fifo_level),
    .overrun_clr  (overrun_clr),
    .irq_rx_data  (irq_rx_data),
    .irq_timeout  (irq_timeout),
    .irq_overrun  (irq_overrun)
  );

  always #5 PCLK = ~PCLK;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  function automatic bit thr_hit(input int n);
    return (rx_threshold != '0) && (n >= int'(rx_threshold));
  endfunction

  // Monitor: every accepted read must present the oldest expected entry.
  logic [DW:0] mon_exp;
  always @(negedge PCLK) begin
    if (PRESETn && pop) begin
      checks++;
      if (fifo_level != '0) begin
        if (sb_q.size() == 0) begin
          failures++;
          $display("FAIL rd_head: got 0x%0h with no entry expected", {rd_err, rd_data});
        end else begin
          mon_exp = sb_q.pop_front();
          if ({rd_err, rd_data} !== mon_exp) begin
            failures++;
            $display("FAIL rd_head: got 0x%0h expected 0x%0h", {rd_err, rd_data}, mon_exp);
          end
        end
      end else if ({rd_err, rd_data} !== '0) begin
        failures++;
        $display("FAIL rd_empty: got 0x%0h expected 0x0", {rd_err, rd_data});
      end
    end
  end

  task automatic do_pop();
    if (model_q.size() > 0) sb_q.push_back(model_q.pop_front());
    pop = 1'b1;
    tick();
    pop = 1'b0;
    chk("lvl_pop", 64'(fifo_level), 64'(model_q.size()));
  endtask

  // One frame: rise, capture edge, push edge, optional flush in HOLD, hold, release.
  task automatic send_frame(input logic [DW-1:0] d, input logic e, input bit pop_c,
                            input bit clr_c, input bit flush_c, input bit flush_h);
    int n0;
    bit ovr_set;
    n0 = model_q.size();
    rx_done = 1'b1;
    rx_data_out = d;
    prx_error = e;
    tick();
    chk("lvl_edge1", 64'(fifo_level), 64'(n0));
    pop = pop_c;
    overrun_clr = clr_c;
    flush = flush_c;
    if (pop_c && n0 > 0) sb_q.push_back(model_q[0]);
    tick();
    pop = 1'b0;
    overrun_clr = 1'b0;
    flush = 1'b0;
    ovr_set = (n0 == DEPTH) && !pop_c;
    if (flush_c) begin
      model_q.delete();
    end else begin
      if (pop_c && n0 > 0) void'(model_q.pop_front());
      if (!ovr_set) model_q.push_back({e, d});
    end
    model_ovr = ovr_set ? 1'b1 : (clr_c ? 1'b0 : model_ovr);
    chk("lvl_push", 64'(fifo_level), 64'(model_q.size()));
    chk("irq_overrun", 64'(irq_overrun), 64'(model_ovr));
    chk("irq_data_lag", 64'(irq_rx_data), 64'(thr_hit(n0)));
    if (flush_h) begin
      flush = 1'b1;
      tick();
      flush = 1'b0;
      model_q.delete();
      chk("lvl_flush", 64'(fifo_level), 64'(0));
    end else begin
      tick();
      chk("irq_data", 64'(irq_rx_data), 64'(thr_hit(model_q.size())));
    end
    repeat ($urandom_range(0, 3)) tick();
    rx_done = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    logic [DW-1:0] w;

    // Reset values
    repeat (3) @(posedge PCLK);
    #1;
    chk("rst_detect", 64'(RX_detect), 64'(0));
    chk("rst_level", 64'(fifo_level), 64'(0));
    chk("rst_rd_data", 64'(rd_data), 64'(0));
    chk("rst_rd_err", 64'(rd_err), 64'(0));
    chk("rst_irq_data", 64'(irq_rx_data), 64'(0));
    chk("rst_irq_to", 64'(irq_timeout), 64'(0));
    chk("rst_irq_ovr", 64'(irq_overrun), 64'(0));
    PRESETn = 1'b1;
    tick();
    chk("detect_off", 64'(RX_detect), 64'(0));
    rx_en = 1'b1;
    tick();
    chk("detect_on", 64'(RX_detect), 64'(1));
    tick();

    // Three ordered frames
    send_frame(32'h41, 1'b0, 0, 0, 0, 0);
    send_frame(32'h42, 1'b0, 0, 0, 0, 0);
    send_frame(32'h43, 1'b0, 0, 0, 0, 0);
    chk("lvl_three", 64'(fifo_level), 64'(3));
    chk("head_first", 64'(rd_data), 64'(32'h41));
    repeat (3) do_pop();
    do_pop();
    chk("empty_data", 64'(rd_data), 64'(0));

    // Data threshold
    rx_threshold = LW'(4);
    repeat (4) send_frame($urandom, 1'($urandom_range(0, 1)), 0, 0, 0, 0);
    chk("thr_set", 64'(irq_rx_data), 64'(1));
    do_pop();
    tick();
    chk("thr_clr", 64'(irq_rx_data), 64'(0));
    rx_threshold = '0;

    // Fill, overrun, set-wins-over-clear, then clear
    while (model_q.size() < DEPTH) send_frame($urandom, 1'($urandom_range(0, 1)), 0, 0, 0, 0);
    send_frame($urandom, 1'b0, 0, 0, 0, 0);
    chk("ovr_full_lvl", 64'(fifo_level), 64'(DEPTH));
    chk("ovr_set", 64'(irq_overrun), 64'(1));
    send_frame($urandom, 1'b0, 0, 1, 0, 0);
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    model_ovr = 1'b0;
    chk("ovr_clr", 64'(irq_overrun), 64'(0));

    // Full FIFO with pop in the capture cycle
    send_frame(32'hA5A5_5A5A, 1'b1, 1, 0, 0, 0);
    chk("fullpop_lvl", 64'(fifo_level), 64'(DEPTH));
    chk("fullpop_ovr", 64'(irq_overrun), 64'(0));
    while (model_q.size() > 0) do_pop();

    // Character timeout
    w = $urandom;
    send_frame(w, 1'b0, 0, 0, 0, 0);
    for (int i = 1; i <= int'(TO) + 4; i++) begin
      rx_tick = 1'b1;
      tick();
      rx_tick = 1'b0;
      if (i == int'(TO) - 1) chk("to_before", 64'(irq_timeout), 64'(0));
      if (i == int'(TO)) chk("to_fire", 64'(irq_timeout), 64'(1));
      tick();
    end
    chk("to_sat", 64'(irq_timeout), 64'(1));
    do_pop();
    chk("to_clr", 64'(irq_timeout), 64'(0));

    // Error flag, flush with push, flush in HOLD, disable
    w = $urandom;
    send_frame(w, 1'b1, 0, 0, 0, 0);
    chk("err_flag", 64'(rd_err), 64'(1));
    chk("err_data", 64'(rd_data), 64'(w));
    send_frame($urandom, 1'b0, 0, 0, 1, 0);
    chk("flush_push_lvl", 64'(fifo_level), 64'(0));
    send_frame($urandom, 1'b1, 0, 0, 0, 0);
    send_frame($urandom, 1'b0, 0, 0, 0, 1);
    chk("flush_hold_err", 64'(rd_err), 64'(0));
    rx_en = 1'b0;
    tick();
    chk("dis_detect", 64'(RX_detect), 64'(0));
    rx_done = 1'b1;
    rx_data_out = $urandom;
    repeat (3) tick();
    rx_done = 1'b0;
    repeat (2) tick();
    chk("dis_ignored", 64'(fifo_level), 64'(0));

    // Reset in the middle of a capture
    rx_en = 1'b1;
    repeat (2) tick();
    rx_done = 1'b1;
    rx_data_out = $urandom;
    tick();
    PRESETn = 1'b0;
    #1;
    chk("rst_mid_lvl", 64'(fifo_level), 64'(0));
    chk("rst_mid_detect", 64'(RX_detect), 64'(0));
    model_q.delete();
    tick();
    PRESETn = 1'b1;
    rx_done = 1'b0;
    repeat (3) tick();
    chk("rst_mid_lost", 64'(fifo_level), 64'(0));

    chk("sb_drained", 64'(sb_q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
